// File: rtl/sm3_feed_pkg.sv
// -----------------------------------------------------------------------------
// sm3_feed_pkg
// Shared definitions for the SM3 message feeder: FSM state encoding, default
// word FIFO depth, counter width and the final-beat byte-enable table.
// -----------------------------------------------------------------------------
package sm3_feed_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W          = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feed_state_t;

    // Byte enables of the final beat, selected by msg_len % 4.
    // Bytes are big-endian, so a partial word fills from bit 31 downward.
    function automatic logic [3:0] last_vld_byte(input logic [1:0] rem);
        logic [3:0] vb;
        case (rem)
            2'd0:    vb = 4'b1111;
            2'd1:    vb = 4'b1000;
            2'd2:    vb = 4'b1100;
            2'd3:    vb = 4'b1110;
            default: vb = 4'b1111;
        endcase
        return vb;
    endfunction

endpackage

// File: rtl/sm3_sync_fifo.sv
// -----------------------------------------------------------------------------
// sm3_sync_fifo
// Single-clock word FIFO with show-ahead head (rd_data is the oldest entry
// whenever empty is low) and a synchronous flush.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         drop all entries (takes priority over wr_en/rd_en)
//   wr_en/wr_data push a word (ignored while full)
//   rd_en         pop the head (ignored while empty)
//   rd_data       current head word
//   empty, full   occupancy flags
// -----------------------------------------------------------------------------
module sm3_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Occupancy flags from pointers carrying one extra wrap bit.
    always_comb begin
        empty   = (wr_ptr_r == rd_ptr_r);
        full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        wr_ok_s = wr_en && !full;
        rd_ok_s = rd_en && !empty;
        rd_data = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointer update; flush and reset empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/sm3_msg_feeder.sv
// -----------------------------------------------------------------------------
// sm3_msg_feeder
// Buffers big-endian message words and streams them as beats to the SM3
// padding stage, marking the final beat and its valid bytes.
// Ports:
//   clk, rst                synchronous active-high reset
//   start, msg_len          begin a message of msg_len bytes
//   abort                   cancel the current message (wins over all)
//   wr_data/wr_vld/wr_rdy   word input handshake
//   msg_inpt_d/_vld_byte/_vld/_lst/_rdy   beat output handshake
//   busy, done              status (done pulses one cycle after last beat)
// -----------------------------------------------------------------------------
module sm3_msg_feeder
    import sm3_feed_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] msg_len,
    input  logic        abort,
    input  logic [31:0] wr_data,
    input  logic        wr_vld,
    output logic        wr_rdy,
    output logic [31:0] msg_inpt_d,
    output logic [3:0]  msg_inpt_vld_byte,
    output logic        msg_inpt_vld,
    output logic        msg_inpt_lst,
    input  logic        msg_inpt_rdy,
    output logic        busy,
    output logic        done
);

    feed_state_t      state_r;
    feed_state_t      state_nxt_s;
    logic [CNT_W-1:0] last_idx_r;   // index of beat N (N-1), avoids storing N itself
    logic [CNT_W-1:0] beat_cnt_r;
    logic [CNT_W-1:0] wr_cnt_r;
    logic             wr_all_r;     // all N words accepted
    logic             empty_msg_r;  // msg_len == 0
    logic [1:0]       rem_r;
    logic [31:0]      msg_len_m1_s;
    logic [31:0]      head_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             run_s;
    logic             start_ok_s;
    logic             last_beat_s;
    logic             xfer_s;
    logic             pop_s;
    logic             wr_acc_s;

    sm3_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .wr_en   (wr_acc_s),
        .wr_data (wr_data),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    // Handshakes and beat outputs; abort masks everything in its own cycle.
    always_comb begin
        run_s        = (state_r == ST_RUN);
        start_ok_s   = start && (state_r == ST_IDLE) && !abort;
        msg_len_m1_s = msg_len - 32'd1;
        last_beat_s  = (beat_cnt_r == last_idx_r);

        wr_rdy       = run_s && !abort && !fifo_full_s && !wr_all_r && !empty_msg_r;
        msg_inpt_vld = run_s && !abort && (empty_msg_r || !fifo_empty_s);
        msg_inpt_lst = msg_inpt_vld && last_beat_s;

        if (!msg_inpt_vld) begin
            msg_inpt_vld_byte = 4'b0000;
        end else if (!last_beat_s) begin
            msg_inpt_vld_byte = 4'b1111;
        end else if (empty_msg_r) begin
            msg_inpt_vld_byte = 4'b0000;
        end else begin
            msg_inpt_vld_byte = last_vld_byte(rem_r);
        end

        if (msg_inpt_vld && !empty_msg_r) begin
            msg_inpt_d = head_s;
        end else begin
            msg_inpt_d = 32'h0000_0000;
        end

        xfer_s   = msg_inpt_vld && msg_inpt_rdy;
        pop_s    = xfer_s && !empty_msg_r;
        wr_acc_s = wr_vld && wr_rdy;
        busy     = (state_r != ST_IDLE) && !abort;
        done     = (state_r == ST_DONE) && !abort;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (xfer_s && last_beat_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Message length capture plus word and beat counters.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            last_idx_r  <= '0;
            beat_cnt_r  <= '0;
            wr_cnt_r    <= '0;
            wr_all_r    <= 1'b0;
            empty_msg_r <= 1'b0;
            rem_r       <= 2'd0;
        end else if (start_ok_s) begin
            last_idx_r  <= (msg_len == 32'd0) ? {CNT_W{1'b0}} : msg_len_m1_s[31:2];
            beat_cnt_r  <= '0;
            wr_cnt_r    <= '0;
            wr_all_r    <= 1'b0;
            empty_msg_r <= (msg_len == 32'd0);
            rem_r       <= msg_len[1:0];
        end else begin
            // Word counter stops at the last index; a flag marks completion
            // so the counter never has to represent N itself.
            if (wr_acc_s) begin
                if (wr_cnt_r == last_idx_r) begin
                    wr_all_r <= 1'b1;
                end else begin
                    wr_cnt_r <= wr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            if (xfer_s && !last_beat_s) begin
                beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_sm3_msg_feeder.sv
// -----------------------------------------------------------------------------
// tb_sm3_msg_feeder
// Table of messages (length, ready pattern, expected beat count, expected
// final byte enables) plus hand-written abort and reset sequences. Expected
// beats are queued as words are accepted and checked as beats transfer.
// -----------------------------------------------------------------------------
module tb_sm3_msg_feeder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] msg_len;
    logic        abort;
    logic [31:0] wr_data;
    logic        wr_vld;
    logic        wr_rdy;
    logic [31:0] msg_inpt_d;
    logic [3:0]  msg_inpt_vld_byte;
    logic        msg_inpt_vld;
    logic        msg_inpt_lst;
    logic        msg_inpt_rdy;
    logic        busy;
    logic        done;

    sm3_msg_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .msg_len           (msg_len),
        .abort             (abort),
        .wr_data           (wr_data),
        .wr_vld            (wr_vld),
        .wr_rdy            (wr_rdy),
        .msg_inpt_d        (msg_inpt_d),
        .msg_inpt_vld_byte (msg_inpt_vld_byte),
        .msg_inpt_vld      (msg_inpt_vld),
        .msg_inpt_lst      (msg_inpt_lst),
        .msg_inpt_rdy      (msg_inpt_rdy),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  vb;
        logic        lst;
    } beat_t;

    typedef struct {
        logic [31:0] len;
        int          mode;     // 0: rdy high, 1: rdy toggles, 2: rdy low 20 cycles
        int          beats;
        logic [3:0]  last_vb;
    } vec_t;

    beat_t      exp_q[$];
    vec_t       vecs[8];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         beats_seen = 0;
    int         done_cnt = 0;
    bit         wr_rdy_seen = 1'b0;
    bit         hold_prev = 1'b0;
    bit         done_expect = 1'b0;
    beat_t      prev_b;
    logic [3:0] last_vb_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_vb(input logic [31:0] len, input bit last);
        int rem;
        if (!last) return 4'b1111;
        if (len == 32'd0) return 4'b0000;
        rem = int'(len % 32'd4);
        case (rem)
            0:       return 4'b1111;
            1:       return 4'b1000;
            2:       return 4'b1100;
            default: return 4'b1110;
        endcase
    endfunction

    // Beat monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (rst) begin
            hold_prev   = 1'b0;
            done_expect = 1'b0;
        end else begin
            cur.d   = msg_inpt_d;
            cur.vb  = msg_inpt_vld_byte;
            cur.lst = msg_inpt_lst;
            if (done_expect) begin
                check("done_pulse", {63'd0, done}, 64'd1);
                check("busy_in_done", {63'd0, busy}, 64'd1);
                done_expect = 1'b0;
                done_cnt++;
            end else if (done) begin
                check("done_spurious", {63'd0, done}, 64'd0);
            end
            if (wr_rdy) wr_rdy_seen = 1'b1;
            if (msg_inpt_vld) begin
                if (hold_prev) check("hold_stable", {27'd0, cur}, {27'd0, prev_b});
                if (msg_inpt_rdy) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_unexpected: got d=0x%0h vb=%b lst=%b expected no beat",
                                 cur.d, cur.vb, cur.lst);
                    end else begin
                        n_tests--;
                        e = exp_q.pop_front();
                        check("beat", {27'd0, cur}, {27'd0, e});
                    end
                    beats_seen++;
                    if (msg_inpt_lst) begin
                        done_expect  = 1'b1;
                        last_vb_seen = msg_inpt_vld_byte;
                    end
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                    prev_b    = cur;
                end
            end else begin
                if (hold_prev && !abort) check("vld_dropped", {63'd0, msg_inpt_vld}, 64'd1);
                hold_prev = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] len);
        @(posedge clk); #1;
        start = 1'b1; msg_len = len; wr_vld = 1'b0; msg_inpt_rdy = 1'b0;
        if (len == 32'd0) exp_q.push_back('{d: 32'd0, vb: 4'b0000, lst: 1'b1});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_msg(input vec_t v);
        int n, widx, d0, cyc;
        bit pend;
        n = (v.len == 32'd0) ? 1 : int'((v.len + 32'd3) / 32'd4);
        beats_seen = 0; wr_rdy_seen = 1'b0; widx = 0; d0 = done_cnt; cyc = 0; pend = 1'b0;
        last_vb_seen = 4'bxxxx;
        pulse_start(v.len);
        while (done_cnt == d0 && cyc < 600) begin
            wr_vld  = (v.len != 32'd0) && (widx < n);
            wr_data = 32'h6162_6300 + 32'(widx) * 32'h0101_0101;
            case (v.mode)
                0:       msg_inpt_rdy = 1'b1;
                1:       msg_inpt_rdy = (cyc % 2) == 1;
                2:       msg_inpt_rdy = (cyc >= 20);
                default: msg_inpt_rdy = 1'b1;
            endcase
            @(negedge clk); #1;
            if (pend) begin
                check("wr_rdy_after_last", {63'd0, wr_rdy}, 64'd0);
                pend = 1'b0;
            end
            if (wr_vld && wr_rdy) begin
                exp_q.push_back('{d: wr_data, vb: exp_vb(v.len, widx == n - 1), lst: (widx == n - 1)});
                widx++;
                if (widx == n) pend = 1'b1;
            end
            if (v.mode == 2 && cyc == 15) begin
                check("stall_words", 64'(widx), 64'(DEPTH));
                check("stall_wr_rdy", {63'd0, wr_rdy}, 64'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 600) check("timeout", 64'(cyc), 64'd0);
        wr_vld = 1'b0; msg_inpt_rdy = 1'b0;
        @(negedge clk); #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("busy_after", {63'd0, busy}, 64'd0);
        check("beat_count", 64'(beats_seen), 64'(v.beats));
        check("last_vb", {60'd0, last_vb_seen}, {60'd0, v.last_vb});
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (v.len == 32'd0) check("wr_rdy_never", {63'd0, wr_rdy_seen}, 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vld"},   {63'd0, msg_inpt_vld}, 64'd0);
        check({tag, "_lst"},   {63'd0, msg_inpt_lst}, 64'd0);
        check({tag, "_wrrdy"}, {63'd0, wr_rdy}, 64'd0);
        check({tag, "_busy"},  {63'd0, busy}, 64'd0);
        check({tag, "_done"},  {63'd0, done}, 64'd0);
        check({tag, "_d"},     {32'd0, msg_inpt_d}, 64'd0);
        check({tag, "_vb"},    {60'd0, msg_inpt_vld_byte}, 64'd0);
    endtask

    initial begin
        int widx, cyc, hold;
        vec_t tail_v;

        vecs[0] = '{len: 32'd3,  mode: 0, beats: 1,  last_vb: 4'b1110};
        vecs[1] = '{len: 32'd0,  mode: 0, beats: 1,  last_vb: 4'b0000};
        vecs[2] = '{len: 32'd64, mode: 1, beats: 16, last_vb: 4'b1111};
        vecs[3] = '{len: 32'd40, mode: 2, beats: 10, last_vb: 4'b1111};
        vecs[4] = '{len: 32'd5,  mode: 0, beats: 2,  last_vb: 4'b1000};
        vecs[5] = '{len: 32'd6,  mode: 1, beats: 2,  last_vb: 4'b1100};
        vecs[6] = '{len: 32'd7,  mode: 0, beats: 2,  last_vb: 4'b1110};
        vecs[7] = '{len: 32'd8,  mode: 1, beats: 2,  last_vb: 4'b1111};

        rst = 1'b1; start = 1'b0; msg_len = 32'd0; abort = 1'b0;
        wr_data = 32'd0; wr_vld = 1'b0; msg_inpt_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_msg(vecs[i]);

        // Abort after 5 beats with words still buffered; start and transfer
        // are offered in the same cycle and must lose.
        beats_seen = 0; widx = 0; cyc = 0; hold = 0;
        pulse_start(32'd64);
        while (cyc < 200 && hold < 3) begin
            wr_vld  = (widx < 16);
            wr_data = 32'hA000_0000 + 32'(widx);
            msg_inpt_rdy = (beats_seen < 5);
            @(negedge clk); #1;
            if (wr_vld && wr_rdy) begin
                exp_q.push_back('{d: wr_data, vb: 4'b1111, lst: (widx == 15)});
                widx++;
            end
            if (beats_seen >= 5) hold++;
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b1; start = 1'b1; msg_len = 32'd4; wr_vld = 1'b1; msg_inpt_rdy = 1'b1;
        @(negedge clk); #1;
        check("abort_cyc_vld",  {63'd0, msg_inpt_vld}, 64'd0);
        check("abort_cyc_busy", {63'd0, busy}, 64'd0);
        check("abort_cyc_done", {63'd0, done}, 64'd0);
        check("abort_cyc_wrrdy", {63'd0, wr_rdy}, 64'd0);
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; wr_vld = 1'b0; msg_inpt_rdy = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("post_abort");
        check("abort_beats", 64'(beats_seen), 64'd5);
        exp_q.delete();
        tail_v = '{len: 32'd4, mode: 0, beats: 1, last_vb: 4'b1111};
        run_msg(tail_v);

        // Reset in the middle of a message with words buffered.
        pulse_start(32'd64);
        for (int k = 0; k < 4; k++) begin
            wr_vld = 1'b1; wr_data = 32'hB000_0000 + 32'(k);
            @(posedge clk); #1;
        end
        rst = 1'b1; msg_inpt_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0; wr_vld = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk); #1;
            check_idle_outputs("after_reset");
        end
        msg_inpt_rdy = 1'b0;
        tail_v = '{len: 32'd7, mode: 1, beats: 2, last_vb: 4'b1110};
        run_msg(tail_v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sm3_msg_feeder.md
SM3_MSG_FEEDER -- requirements
Module: sm3_msg_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning word FIFO depth (power of two, >=2).
REQ-002 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a message.
- msg_len  in  32  message length in bytes, sampled on start.
- abort  in  1  one-cycle pulse that cancels the current message.
- wr_data  in  32  message word, big-endian: first byte in [31:24].
- wr_vld  in  1  wr_data valid.
- wr_rdy  out  1  feeder accepts wr_data.
- msg_inpt_d  out  32  word to the SM3 padding stage.
- msg_inpt_vld_byte  out  4  byte enables, bit3 = [31:24].
- msg_inpt_vld  out  1  beat valid.
- msg_inpt_lst  out  1  final beat of the message.
- msg_inpt_rdy  in  1  SM3 padding stage accepts the beat.
- busy  out  1  message in progress.
- done  out  1  one-cycle pulse after the last beat transfers.

Function
REQ-003 SHALL compute beat count N = ceil(msg_len/4) at start; msg_len=0 SHALL give N=1 (empty beat).
REQ-004 SHALL implement FSM IDLE->RUN on start; RUN->DONE on transfer of beat N; DONE->IDLE unconditionally after 1 cycle.
REQ-005 SHALL ignore start in RUN and DONE.
REQ-006 SHALL accept a write when wr_vld && wr_rdy.
REQ-007 wr_rdy SHALL be high only in RUN, with FIFO not full, and words accepted < N (msg_len=0 accepts none).
REQ-008 SHALL present the FIFO head on msg_inpt_d; msg_inpt_vld high in RUN when FIFO non-empty, or for msg_len=0 while the empty beat is pending.
REQ-009 SHALL transfer a beat on msg_inpt_vld && msg_inpt_rdy and pop the FIFO in that same cycle.
REQ-010 Once msg_inpt_vld is high, d, vld_byte and lst SHALL hold stable until transfer.
REQ-011 msg_inpt_lst SHALL be high only on beat N.
REQ-012 vld_byte SHALL be 4'b1111 on beats 1..N-1; on beat N, by msg_len%4: 0->1111, 1->1000, 2->1100, 3->1110; msg_len=0 ->0000.
REQ-013 A simultaneous write and pop on a full FIFO SHALL NOT be possible, since wr_rdy is low when full. A simultaneous write and pop on a non-full FIFO SHALL keep occupancy unchanged.
REQ-014 Beat and word counters SHALL be 30 bits and SHALL not wrap within a message.
REQ-015 busy SHALL be high in RUN and DONE; done SHALL be high only in DONE.
REQ-016 abort SHALL, in any state, return the FSM to IDLE next cycle, flush the FIFO, and clear counters. Outputs SHALL show vld=0, busy=0, done=0 that cycle.
REQ-017 abort SHALL win over a simultaneous start or transfer.

Reset
REQ-018 rst SHALL force IDLE, an empty FIFO, zero counters, and msg_inpt_vld, msg_inpt_lst, wr_rdy, busy, done =0.
REQ-019 rst SHALL force msg_inpt_d=0 and vld_byte=0.
REQ-020 rst mid-message SHALL behave identically to REQ-018; no beat SHALL follow.

Structure
REQ-021 FSM state encoding, FIFO_DEPTH default, and the msg_len%4->vld_byte table SHALL live in shared package sm3_feed_pkg.
REQ-022 The FIFO SHALL be sub-module sm3_sync_fifo (32-bit, FIFO_DEPTH, registered storage, show-ahead head, flush input).

Verification
REQ-023 start, msg_len=3, write 0x61626300 -> one beat d=0x61626300, vld_byte=1110, lst=1; done pulse one cycle later.
REQ-024 start, msg_len=0, no writes -> one beat vld_byte=0000, lst=1; wr_rdy never high.
REQ-025 start, msg_len=64, rdy toggling each cycle -> 16 beats in order, vld_byte=1111, lst only on beat 16; wr_rdy low after the 16th write; data stable while rdy low.
REQ-026 start, msg_len=40, msg_inpt_rdy=0 -> wr_rdy drops after 8 writes; raising rdy drains 10 beats, last vld_byte=1111.
REQ-027 abort after 5 of 16 beats -> next cycle vld=0, busy=0, FIFO empty; then start, msg_len=4 -> single clean beat.
REQ-028 rst asserted mid-message and released -> all outputs are at reset values; the next message completes correctly.
